sdram_rom_arbiter: RTL

SDRAM_ROM_ARBITER -- requirements
Module: sdram_rom_arbiter

---
 rtl/sdram_rom_arbiter_if.sv | 45 ++++
 rtl/sdram_rom_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_arbiter_if.sv
// Bus bundle for the SDRAM ROM arbiter: ROM read channels, byte download stream and the
// single-port SDRAM request interface. The arbiter connects as "slave" (it serves the
// channels and the download stream); the surrounding system connects as "master".
interface sdram_rom_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 23
);
  // ROM read channels
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*32-1:0]     ch_q;

  // Byte download stream
  logic        dl_en;
  logic        dl_wr;
  logic [15:0] dl_index;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_overrun;

  // SDRAM side
  logic [ADDR_W-1:0] sdram_addr;
  logic [31:0]       sdram_data;
  logic              sdram_we;
  logic              sdram_req;
  logic              sdram_ack;
  logic              sdram_valid;
  logic [31:0]       sdram_q;

  modport slave (
    input  ch_req, ch_addr, dl_en, dl_wr, dl_index, dl_addr, dl_data,
           sdram_ack, sdram_valid, sdram_q,
    output ch_ack, ch_valid, ch_q, dl_overrun,
           sdram_addr, sdram_data, sdram_we, sdram_req
  );

  modport master (
    output ch_req, ch_addr, dl_en, dl_wr, dl_index, dl_addr, dl_data,
           sdram_ack, sdram_valid, sdram_q,
    input  ch_ack, ch_valid, ch_q, dl_overrun,
           sdram_addr, sdram_data, sdram_we, sdram_req
  );
endinterface

// File: rtl/sdram_rom_arbiter.sv
// SDRAM ROM arbiter: a one-entry read cache per channel, refilled from SDRAM through a
// single outstanding transaction, plus a byte-to-word download path that writes SDRAM
// and invalidates every cache entry while a download is active.
module sdram_rom_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned RR_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  sdram_rom_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  logic [1:0]           state_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [ADDR_W-1:0]    tag_q [NUM_CH];
  logic [NUM_CH-1:0]    tag_valid_q;
  logic [NUM_CH*32-1:0] data_q;
  logic [NUM_CH-1:0]    ack_q;
  logic [23:0]          byte_buf_q;
  logic [31:0]          wr_data_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic                 wr_pending_q;
  logic                 overrun_q;

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] miss;
  logic              pick_found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W:0]    rr_idx;
  logic              dl_write;
  logic              unused_dl;

  // Upper download address bits beyond the SDRAM word range are don't-care.
  assign unused_dl = ^bus.dl_addr;

  assign dl_write = bus.dl_en & bus.dl_wr & (bus.dl_index == 16'd0);

  // Cache hit is combinational so a repeated address is served in the request cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = bus.ch_req[i] & tag_valid_q[i] &
               (bus.ch_addr[i*ADDR_W +: ADDR_W] == tag_q[i]);
    end
    miss = bus.ch_req & ~hit;
  end

  // Pick the next channel to refill: lowest index, or round-robin after last_grant.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    rr_idx     = '0;
    if (RR_MODE == 0) begin
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (miss[i]) begin
          pick_found = 1'b1;
          pick       = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= int'(NUM_CH); k++) begin
        rr_idx = {1'b0, last_grant_q} + (IDX_W + 1)'(k);
        if (rr_idx >= NUM_CH_L) begin
          rr_idx = rr_idx - NUM_CH_L;
        end
        if (!pick_found && miss[rr_idx[IDX_W-1:0]]) begin
          pick_found = 1'b1;
          pick       = rr_idx[IDX_W-1:0];
        end
      end
    end
  end

  // FSM, cache fill, download packing and overrun tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      rd_addr_q    <= '0;
      tag_valid_q  <= '0;
      data_q       <= '0;
      ack_q        <= '0;
      byte_buf_q   <= '0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_pending_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ack_q <= '0;
      if (bus.dl_en) begin
        tag_valid_q <= '0;
      end

      if (dl_write) begin
        case (bus.dl_addr[1:0])
          2'd0: byte_buf_q[7:0]   <= bus.dl_data;
          2'd1: byte_buf_q[15:8]  <= bus.dl_data;
          2'd2: byte_buf_q[23:16] <= bus.dl_data;
          default: begin
            // A word completing while the previous one is still queued is lost.
            if (wr_pending_q) begin
              overrun_q <= 1'b1;
            end else begin
              wr_pending_q <= 1'b1;
              wr_data_q    <= {bus.dl_data, byte_buf_q};
              wr_addr_q    <= bus.dl_addr[ADDR_W+1:2];
            end
          end
        endcase
      end

      case (state_q)
        IDLE: begin
          if (wr_pending_q) begin
            state_q <= WR_REQ;
          end else if (!bus.dl_en && pick_found) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            rd_addr_q    <= bus.ch_addr[int'(pick)*ADDR_W +: ADDR_W];
            state_q      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bus.sdram_ack) begin
            ack_q[grant_q] <= 1'b1;
            state_q        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.sdram_valid) begin
            // Data fetched before a download may be stale, so it is dropped.
            if (!bus.dl_en) begin
              tag_q[grant_q]            <= rd_addr_q;
              tag_valid_q[grant_q]      <= 1'b1;
              data_q[grant_q*32 +: 32]  <= bus.sdram_q;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          if (bus.sdram_ack) begin
            wr_pending_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  // SDRAM request outputs decoded from the FSM state.
  always_comb begin
    bus.sdram_req  = 1'b0;
    bus.sdram_we   = 1'b0;
    bus.sdram_addr = '0;
    bus.sdram_data = '0;
    case (state_q)
      RD_REQ: begin
        bus.sdram_req  = 1'b1;
        bus.sdram_addr = rd_addr_q;
      end
      WR_REQ: begin
        bus.sdram_req  = 1'b1;
        bus.sdram_we   = 1'b1;
        bus.sdram_addr = wr_addr_q;
        bus.sdram_data = wr_data_q;
      end
      default: ;
    endcase
  end

  assign bus.ch_valid   = hit;
  assign bus.ch_ack     = ack_q;
  assign bus.ch_q       = data_q;
  assign bus.dl_overrun = overrun_q;

endmodule
